// File: rtl/spw_pkg.sv
// spw_pkg: shared constants and types for the SpaceWire TX packet feeder.
//   SPW_RUN      transceiver link FSM encoding of the Run state
//   SPW_EOP/EEP  9-bit control N-chars written to the transceiver FIFO
//   fsm_state_t  feeder FSM state encoding
//   crc8_next    one-byte CRC-8 update (poly 0x07, MSB first)
package spw_pkg;

   localparam logic [2:0] SPW_RUN = 3'd5;
   localparam logic [8:0] SPW_EOP = 9'h100;
   localparam logic [8:0] SPW_EEP = 9'h101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DATA  = 3'd1,
      ST_CRC   = 3'd2,
      ST_TERM  = 3'd3,
      ST_FLUSH = 3'd4
   } fsm_state_t;

   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

endpackage

// File: rtl/spw_crc8.sv
// spw_crc8: running CRC-8 over payload bytes (poly 0x07, init 0x00, MSB first).
// Only built when SPW_TX_CRC8_EN is defined; the feeder has no CRC otherwise.
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         restart the CRC at 8'h00 (has priority over en)
//   en          fold data into the CRC this cycle
//   data        payload byte
//   crc         current CRC value (registered)
`ifdef SPW_TX_CRC8_EN
module spw_crc8
   import spw_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= 8'h00;
      end else if (clr) begin
         crc <= 8'h00;
      end else if (en) begin
         crc <= crc8_next(crc, data);
      end
   end

endmodule
`endif

// File: rtl/spw_tx_packet_feeder.sv
// spw_tx_packet_feeder: turns a length-prefixed byte stream into SpaceWire
// N-chars for the transceiver TX FIFO and appends EOP (EEP on abort).
// Optional macro SPW_TX_CRC8_EN appends one CRC-8 byte before EOP.
//
// Ports:
//   CLOCK, RESETn            clock, asynchronous active-low reset
//   CURRENTSTATE[2:0]        transceiver link state (Run = 3'd5)
//   PKT_START, PKT_LEN       start request and payload length (IDLE only)
//   BYTE_IN/VALID/READY      payload byte handshake
//   PKT_ABORT                terminate current packet with EEP
//   BUSY                     high whenever not IDLE
//   PKT_DONE, PKT_ERR        one-cycle end-of-packet pulses (EOP / EEP or link loss)
//   DATA_I[8:0], WR_DATA     FIFO write port
//   TX_FULL                  FIFO full
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for PKT_START
// ST_DATA  | accepting payload bytes into the hold register
// ST_CRC   | loading the CRC byte (SPW_TX_CRC8_EN only)
// ST_TERM  | loading EOP, or EEP if the packet was aborted
// ST_FLUSH | waiting for the terminator to be written to the FIFO
module spw_tx_packet_feeder
   import spw_pkg::*;
#(
   parameter int MAX_LEN_W = 16
)(
   input  logic                 CLOCK,
   input  logic                 RESETn,
   input  logic [2:0]           CURRENTSTATE,
   input  logic                 PKT_START,
   input  logic [MAX_LEN_W-1:0] PKT_LEN,
   input  logic [7:0]           BYTE_IN,
   input  logic                 BYTE_VALID,
   output logic                 BYTE_READY,
   input  logic                 PKT_ABORT,
   output logic                 BUSY,
   output logic                 PKT_DONE,
   output logic                 PKT_ERR,
   output logic [8:0]           DATA_I,
   output logic                 WR_DATA,
   input  logic                 TX_FULL
);

   fsm_state_t           state_q;
   logic [MAX_LEN_W-1:0] remaining_q;
   logic [8:0]           hold_q;
   logic                 hold_v;
   logic                 abort_q;
   logic                 link_run_q;

   logic                 link_run;
   logic                 wr;
   logic                 hold_free;
   logic                 xfer;
   logic                 link_loss;
   logic [8:0]           term_char;

   assign link_run   = (CURRENTSTATE == SPW_RUN);
   assign wr         = hold_v & ~TX_FULL & link_run;
   assign hold_free  = ~hold_v | wr;
   assign BYTE_READY = (state_q == ST_DATA) & hold_free & link_run;
   assign xfer       = BYTE_VALID & BYTE_READY;
   // Loss is the Run -> not-Run transition; a packet started while the link
   // is down simply stalls until Run.
   assign link_loss  = (state_q != ST_IDLE) & link_run_q & ~link_run;
   assign term_char  = (abort_q | PKT_ABORT) ? SPW_EEP : SPW_EOP;

   assign WR_DATA = wr;
   assign DATA_I  = hold_q;
   assign BUSY    = (state_q != ST_IDLE);

`ifdef SPW_TX_CRC8_EN
   logic       crc_clr;
   logic [7:0] crc_val;

   assign crc_clr = (state_q == ST_IDLE) & PKT_START;

   spw_crc8 u_crc8 (
      .clk   (CLOCK),
      .rst_n (RESETn),
      .clr   (crc_clr),
      .en    (xfer),
      .data  (BYTE_IN),
      .crc   (crc_val)
   );

   localparam fsm_state_t ST_AFTER_DATA = ST_CRC;
`else
   localparam fsm_state_t ST_AFTER_DATA = ST_TERM;
`endif

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         hold_q      <= 9'h000;
         hold_v      <= 1'b0;
         abort_q     <= 1'b0;
         link_run_q  <= 1'b0;
         PKT_DONE    <= 1'b0;
         PKT_ERR     <= 1'b0;
      end else begin
         link_run_q <= link_run;
         PKT_DONE   <= 1'b0;
         PKT_ERR    <= 1'b0;
         if (wr) hold_v <= 1'b0;

         if (link_loss) begin
            // Link layer discards the partial packet, so no EEP is queued.
            state_q     <= ST_IDLE;
            hold_v      <= 1'b0;
            abort_q     <= 1'b0;
            remaining_q <= '0;
            PKT_ERR     <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (PKT_START) begin
                     remaining_q <= PKT_LEN;
                     abort_q     <= 1'b0;
                     state_q     <= (PKT_LEN != '0) ? ST_DATA : ST_AFTER_DATA;
                  end
               end
               ST_DATA: begin
                  if (xfer) begin
                     hold_q <= {1'b0, BYTE_IN};
                     hold_v <= 1'b1;
                     if (remaining_q != '0) remaining_q <= remaining_q - MAX_LEN_W'(1);
                  end
                  if (PKT_ABORT) begin
                     abort_q <= 1'b1;
                     state_q <= ST_TERM;
                  end else if (xfer && remaining_q == MAX_LEN_W'(1)) begin
                     state_q <= ST_AFTER_DATA;
                  end
               end
`ifdef SPW_TX_CRC8_EN
               ST_CRC: begin
                  if (PKT_ABORT) begin
                     abort_q <= 1'b1;
                     state_q <= ST_TERM;
                  end else if (hold_free) begin
                     hold_q  <= {1'b0, crc_val};
                     hold_v  <= 1'b1;
                     state_q <= ST_TERM;
                  end
               end
`endif
               ST_TERM: begin
                  if (PKT_ABORT) abort_q <= 1'b1;
                  if (hold_free) begin
                     hold_q  <= term_char;
                     hold_v  <= 1'b1;
                     state_q <= ST_FLUSH;
                  end
               end
               ST_FLUSH: begin
                  if (wr && hold_q[8]) begin
                     state_q <= ST_IDLE;
                     if (hold_q == SPW_EOP) PKT_DONE <= 1'b1;
                     else                   PKT_ERR  <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spw_tx_packet_feeder.sv
// Testbench for spw_tx_packet_feeder. Expected N-char stream is built from
// the payload the bench sends plus the packet outcome it requests; every
// FIFO write is compared against it. Honours SPW_TX_CRC8_EN.
module tb_spw_tx_packet_feeder;

   localparam int MAX_LEN_W = 16;

   logic                 CLOCK = 1'b0;
   logic                 RESETn = 1'b0;
   logic [2:0]           CURRENTSTATE = 3'd5;
   logic                 PKT_START = 1'b0;
   logic [MAX_LEN_W-1:0] PKT_LEN = '0;
   logic [7:0]           BYTE_IN = 8'h00;
   logic                 BYTE_VALID = 1'b0;
   logic                 BYTE_READY;
   logic                 PKT_ABORT = 1'b0;
   logic                 BUSY;
   logic                 PKT_DONE;
   logic                 PKT_ERR;
   logic [8:0]           DATA_I;
   logic                 WR_DATA;
   logic                 TX_FULL = 1'b0;

   spw_tx_packet_feeder #(.MAX_LEN_W(MAX_LEN_W)) dut (
      .CLOCK        (CLOCK),
      .RESETn       (RESETn),
      .CURRENTSTATE (CURRENTSTATE),
      .PKT_START    (PKT_START),
      .PKT_LEN      (PKT_LEN),
      .BYTE_IN      (BYTE_IN),
      .BYTE_VALID   (BYTE_VALID),
      .BYTE_READY   (BYTE_READY),
      .PKT_ABORT    (PKT_ABORT),
      .BUSY         (BUSY),
      .PKT_DONE     (PKT_DONE),
      .PKT_ERR      (PKT_ERR),
      .DATA_I       (DATA_I),
      .WR_DATA      (WR_DATA),
      .TX_FULL      (TX_FULL)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q[$];
   logic [8:0] wlog[$];
   int         wcyc[$];
   logic [7:0] pay_q[$];
   logic [8:0] exp_n;
   int         done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
   int         first_acc = 0, last_acc = 0;
   bit         first_seen = 0;
   int         base, d0, e0, bad, tmo;

   // CRC-8 of the current payload as polynomial division of msg*x^8 by 0x107.
   function automatic logic [7:0] crc_model();
      logic [8:0] r;
      r = 9'h000;
      foreach (pay_q[k]) begin
         for (int i = 7; i >= 0; i--) begin
            r = {r[7:0], pay_q[k][i]};
            if (r[8]) r = r ^ 9'h107;
         end
      end
      for (int i = 0; i < 8; i++) begin
         r = {r[7:0], 1'b0};
         if (r[8]) r = r ^ 9'h107;
      end
      return r[7:0];
   endfunction

   // Stream compare: every FIFO write must be the next expected N-char,
   // and never while TX_FULL or the link is not in Run.
   always @(negedge CLOCK) begin
      if (RESETn) begin
         if (WR_DATA) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream: unexpected write DATA_I=%h", DATA_I);
            end else begin
               exp_n = exp_q.pop_front();
               if (DATA_I !== exp_n || TX_FULL || CURRENTSTATE != 3'd5) begin
                  errors++;
                  $display("FAIL stream: DATA_I=%h expected %h (TX_FULL=%b link=%0d)",
                           DATA_I, exp_n, TX_FULL, CURRENTSTATE);
               end
            end
            wlog.push_back(DATA_I);
            wcyc.push_back(cyc);
         end
         if (PKT_DONE === 1'b1) done_cnt++;
         if (PKT_ERR === 1'b1) err_cnt++;
      end
   end

   function automatic logic [8:0] wl(input int i);
      if (i >= 0 && i < wlog.size()) return wlog[i];
      return 9'h1FF;
   endfunction

   function automatic int wc(input int i);
      if (i >= 0 && i < wcyc.size()) return wcyc[i];
      return -1000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic start_pkt(input logic [MAX_LEN_W-1:0] len);
      pay_q.delete();
      first_seen = 0;
      PKT_START  = 1'b1;
      PKT_LEN    = len;
      step();
      PKT_START  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bit acc = 0;
      BYTE_IN    = b;
      BYTE_VALID = 1'b1;
      while (!acc && t < 200) begin
         @(negedge CLOCK);
         if (BYTE_READY) acc = 1;
         else t++;
      end
      if (acc) begin
         if (!first_seen) begin
            first_acc  = cyc;
            first_seen = 1;
         end
         last_acc = cyc;
         pay_q.push_back(b);
         exp_q.push_back({1'b0, b});
      end else begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: BYTE_READY stayed 0 for byte %h", b);
      end
      step();
      BYTE_VALID = 1'b0;
   endtask

   task automatic end_ok();
`ifdef SPW_TX_CRC8_EN
      exp_q.push_back({1'b0, crc_model()});
`endif
      exp_q.push_back(9'h100);
      exp_done++;
   endtask

   task automatic end_abort();
      PKT_ABORT = 1'b1;
      exp_q.push_back(9'h101);
      exp_err++;
      step();
      PKT_ABORT = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (BUSY && t < 500) begin
         @(negedge CLOCK);
         t++;
      end
      if (t >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: BUSY=%b after %0d cycles, expected 0", BUSY, t);
      end
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge CLOCK);
      #1;
      chk("rst_busy",  BUSY, 0);
      chk("rst_ready", BYTE_READY, 0);
      chk("rst_wr",    WR_DATA, 0);
      chk("rst_data",  DATA_I, 9'h000);
      chk("rst_done",  PKT_DONE, 0);
      chk("rst_err",   PKT_ERR, 0);
      RESETn = 1'b1;
      step();

      // Streaming packet A1,B2,C3
      base = wlog.size();
      d0   = done_cnt;
      start_pkt(3);
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      end_ok();
      wait_idle();
      chk("t1_byte0", wl(base),     9'h0A1);
      chk("t1_byte1", wl(base + 1), 9'h0B2);
      chk("t1_byte2", wl(base + 2), 9'h0C3);
`ifdef SPW_TX_CRC8_EN
      chk("t1_eop",     wl(base + 4), 9'h100);
      chk("t1_eop_lat", wc(base + 4) - last_acc, 3);
`else
      chk("t1_eop",     wl(base + 3), 9'h100);
      chk("t1_eop_lat", wc(base + 3) - last_acc, 2);
`endif
      chk("t1_back_to_back", wc(base + 2) - wc(base), 2);
      chk("t1_first_lat",    wc(base) - first_acc, 1);
      chk("t1_done_pulses",  done_cnt - d0, 1);

      // TX_FULL stall mid-packet
      base = wlog.size();
      start_pkt(4);
      send_byte(8'h11);
      send_byte(8'h22);
      TX_FULL    = 1'b1;
      BYTE_IN    = 8'h33;
      BYTE_VALID = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge CLOCK);
         if (WR_DATA || BYTE_READY) bad++;
      end
      step();
      TX_FULL = 1'b0;
      send_byte(8'h33);
      send_byte(8'h44);
      end_ok();
      wait_idle();
      chk("t2_stall_activity", bad, 0);
      chk("t2_byte2", wl(base + 2), 9'h033);
`ifdef SPW_TX_CRC8_EN
      chk("t2_count", wlog.size() - base, 6);
`else
      chk("t2_count", wlog.size() - base, 5);
`endif

      // Abort after 2 of 4 bytes
      base = wlog.size();
      d0   = done_cnt;
      e0   = err_cnt;
      start_pkt(4);
      send_byte(8'hAA);
      send_byte(8'hBB);
      end_abort();
      wait_idle();
      chk("t3_count", wlog.size() - base, 3);
      chk("t3_eep",   wl(base + 2), 9'h101);
      chk("t3_err",   err_cnt - e0, 1);
      chk("t3_done",  done_cnt - d0, 0);

      // Link loss after first byte
      base = wlog.size();
      e0   = err_cnt;
      start_pkt(3);
      send_byte(8'h5A);
      tmo = 0;
      while (wlog.size() == base && tmo < 50) begin
         @(negedge CLOCK);
         tmo++;
      end
      step();
      CURRENTSTATE = 3'd2;
      exp_err++;
      step();
      @(negedge CLOCK);
      chk("t4_busy", BUSY, 0);
      chk("t4_err_pulse", PKT_ERR, 1);
      step();
      step();
      chk("t4_writes", wlog.size() - base, 1);
      chk("t4_err", err_cnt - e0, 1);
      CURRENTSTATE = 3'd5;
      step();
      step();
      base = wlog.size();
      start_pkt(1);
      send_byte(8'h77);
      end_ok();
      wait_idle();
      chk("t4_restart", wl(base), 9'h077);

      // Zero-length packet
      base = wlog.size();
      start_pkt(0);
      end_ok();
      wait_idle();
`ifdef SPW_TX_CRC8_EN
      chk("t5_count", wlog.size() - base, 2);
      chk("t5_crc",   wl(base), 9'h000);
      chk("t5_eop",   wl(base + 1), 9'h100);
`else
      chk("t5_count", wlog.size() - base, 1);
      chk("t5_eop",   wl(base), 9'h100);
`endif

      // Start while link not Run: accepted, data stalls until Run
      CURRENTSTATE = 3'd2;
      step();
      base = wlog.size();
      start_pkt(1);
      chk("t6_busy", BUSY, 1);
      BYTE_IN    = 8'h3C;
      BYTE_VALID = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge CLOCK);
         if (BYTE_READY || WR_DATA) bad++;
      end
      chk("t6_stall", bad, 0);
      step();
      CURRENTSTATE = 3'd5;
      send_byte(8'h3C);
      end_ok();
      wait_idle();
      chk("t6_byte", wl(base), 9'h03C);

      // Single payload byte 01 (CRC-8 is 07)
      base = wlog.size();
      start_pkt(1);
      send_byte(8'h01);
      end_ok();
      wait_idle();
      chk("t7_byte", wl(base), 9'h001);
`ifdef SPW_TX_CRC8_EN
      chk("t7_crc", wl(base + 1), 9'h007);
      chk("t7_eop", wl(base + 2), 9'h100);
`else
      chk("t7_eop", wl(base + 1), 9'h100);
`endif

      // Reset mid-packet with a byte parked in the hold register
      start_pkt(3);
      TX_FULL = 1'b1;
      send_byte(8'h9C);
      RESETn  = 1'b0;
      TX_FULL = 1'b0;
      #1;
      chk("t8_busy",  BUSY, 0);
      chk("t8_wr",    WR_DATA, 0);
      chk("t8_data",  DATA_I, 9'h000);
      chk("t8_ready", BYTE_READY, 0);
      chk("t8_err",   PKT_ERR, 0);
      exp_q.delete();
      step();
      step();
      RESETn = 1'b1;
      step();
      step();

      chk("end_drained",   exp_q.size(), 0);
      chk("end_done_total", done_cnt, exp_done);
      chk("end_err_total",  err_cnt, exp_err);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spw_tx_packet_feeder.md
# spw_tx_packet_feeder

Host-side packet feeder that sits directly upstream of the SpaceWire transceiver's transmit FIFO port (DATA_I / WR_DATA / TX_FULL). Accepts a length-prefixed packet as a byte stream with valid/ready handshake, converts bytes to 9-bit N-chars, and appends the EOP (or EEP on abort) marker. Writes are held off by TX_FULL and by the link not being in Run, so the transceiver FIFO never overflows.

## Interface
- MAX_LEN_W, 16, width of packet length field (max packet 2^16-1 bytes)
- CLOCK  in  1  system clock, same domain as transceiver CLOCK
- RESETn  in  1  asynchronous, active-low reset
- CURRENTSTATE  in  3  transceiver link FSM state; Run = 3'd5
- PKT_START  in  1  one-cycle request to start a packet (sampled only in IDLE)
- PKT_LEN  in  MAX_LEN_W  payload byte count, latched on PKT_START
- BYTE_IN  in  8  payload byte
- BYTE_VALID  in  1  BYTE_IN valid
- BYTE_READY  out  1  feeder accepts BYTE_IN this cycle
- PKT_ABORT  in  1  host abort; terminate current packet with EEP
- BUSY  out  1  high in every state except IDLE
- PKT_DONE  out  1  one-cycle pulse when EOP written to FIFO
- PKT_ERR  out  1  one-cycle pulse when packet ends by EEP or link loss
- DATA_I  out  9  N-char to transceiver: {0,byte} data, 9'h100 EOP, 9'h101 EEP
- WR_DATA  out  1  FIFO write strobe
- TX_FULL  in  1  transceiver TX FIFO full

## Operation
- One-entry hold register (hold_q[8:0], hold_v) between FSM and FIFO: WR_DATA = hold_v & ~TX_FULL & link_run (link_run = CURRENTSTATE==3'd5); DATA_I = hold_q. Hold is free when ~hold_v or WR_DATA.
- FSM states: IDLE, DATA, CRC (macro only), TERM, FLUSH.
- IDLE: PKT_START=1 -> latch remaining = PKT_LEN, clear CRC; go DATA if PKT_LEN≠0, else CRC/TERM.
- DATA: BYTE_READY = hold free & link_run. Transfer (BYTE_VALID & BYTE_READY) loads {0,BYTE_IN} into hold, remaining -= 1; on remaining==1 transfer go CRC (macro) or TERM.
- CRC: when hold free, load {0,crc} -> TERM.
- TERM: when hold free, load 9'h100 (EOP) -> FLUSH.
- FLUSH: when the terminator is written (WR_DATA with hold_q[8]=1) -> IDLE; pulse PKT_DONE for EOP, PKT_ERR for EEP.
- PKT_ABORT in DATA/CRC/TERM: next terminator loaded is 9'h101 (EEP) instead of remaining data/CRC/EOP; pending data byte in hold is still written first. Abort in FLUSH or IDLE ignored.
- Link loss: CURRENTSTATE leaves 3'd5 while BUSY -> hold_v cleared, FSM to IDLE, PKT_ERR pulse; no EEP generated (link layer discards).
- PKT_START while BUSY ignored. Simultaneous PKT_START and link not Run in IDLE: packet accepted, data stalls until Run.

## Timing
- Reset: state IDLE, hold_v=0, hold_q=0, remaining=0; outputs BUSY=0, BYTE_READY=0, WR_DATA=0, DATA_I=9'h000, PKT_DONE=0, PKT_ERR=0.
- Byte accepted cycle N -> WR_DATA earliest cycle N+1; sustained throughput one byte/cycle while ~TX_FULL.
- TX_FULL and link_run are combinational into WR_DATA and BYTE_READY; all other outputs registered.
- Last byte accepted cycle N -> EOP written earliest N+2 (N+3 with CRC); PKT_DONE in same cycle as EOP write.
- remaining is MAX_LEN_W unsigned, never wraps (decrement only on transfer with remaining≥1).

## Configuration
- SPW_TX_CRC8_EN defined: one CRC-8 byte (poly 0x07, init 0x00, MSB-first over payload bytes) inserted before EOP; skipped on abort. Zero-length packet sends 8'h00 then EOP.
- Undefined: CRC state and logic absent; DATA -> TERM directly.

## Structure
- Package spw_pkg: link state constant SPW_RUN=3'd5, N-char constants SPW_EOP=9'h100, SPW_EEP=9'h101, FSM state enum.
- Sub-module spw_crc8 (byte-wide combinational update + register, clear/enable), instantiated only under SPW_TX_CRC8_EN.

## Test plan
- Link Run, PKT_LEN=3, bytes 8'hA1,8'hB2,8'hC3 streaming -> DATA_I 9'h0A1,9'h0B2,9'h0C3,9'h100 on consecutive WR_DATA; PKT_DONE once.
- TX_FULL held high 5 cycles mid-packet -> no WR_DATA, BYTE_READY=0, byte order and count preserved after release.
- PKT_ABORT after 2 of 4 bytes -> writes 2 data N-chars then 9'h101; PKT_ERR pulse, no PKT_DONE.
- CURRENTSTATE 5->2 after first byte -> no further writes, BUSY=0 next cycle, PKT_ERR pulse; new PKT_START accepted later.
- PKT_LEN=0 -> only 9'h100 (with SPW_TX_CRC8_EN: 9'h000 then 9'h100).
- SPW_TX_CRC8_EN, payload 8'h01 -> CRC byte 8'h07 before EOP; RESETn asserted mid-packet -> all outputs to reset values immediately.
